mux8_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 8:1 single-bit mux path among 8 requesters.

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/rr_pick8.sv | 37 +++
 rtl/mux8_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter.
// Contents: requester count, select width, FSM state enum, one-hot helper.
// No logic here; imported by rr_pick8 and mux8_rr_arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Decode a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick: first set req bit searching last+1, last+2, ... (mod 8).
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates every cycle.
// Ports: req[7:0] request vector, last[2:0] previous holder (lowest priority),
//        pick[2:0] chosen index (valid when any=1), any = |req.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);

  logic [SEL_W-1:0]     start;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     enc;

  // Rotate so that bit 0 of rot is requester last+1; the old holder lands in bit 7.
  assign start = last + SEL_W'(1);
  assign dbl   = {req, req} >> start;
  assign rot   = dbl[NUM_REQ-1:0];
  assign any   = |req;

  // Lowest set bit of the rotated vector wins; scanning downward lets it overwrite.
  always_comb begin
    enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = SEL_W'(i);
    end
  end

  // Un-rotate back into absolute requester numbering (wraps mod 8).
  assign pick = start + enc;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 single-bit mux; each grant lasts up to HOLD_CYCLES.
// Latency: req -> gnt/sel3/busy 1 cycle; gnt -> out/valid 1 further cycle.
// Backpressure: none; requests are level-sensitive and simply wait for their turn.
// Ports: clk, rst (sync, active-high), req[7:0], in8[7:0] in;
//        gnt[7:0] one-hot grant, sel3[2:0] mux select, busy, out (steered bit), valid out.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int HOLD_CYCLES = 4,
  localparam int CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] in8,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel3,
  output logic               busy,
  output logic               out,
  output logic               valid
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [SEL_W-1:0]   sel3_q,  sel3_d;
  logic [SEL_W-1:0]   last_q,  last_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic               out_q,   out_d;
  logic               valid_q, valid_d;

  logic [SEL_W-1:0]   pick;
  logic               any;

  rr_pick8 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel3_d  = sel3_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;

    // Output stage steers with the select currently on the register, so the
    // bit seen downstream is in8[sel3] one cycle after the grant appears.
    out_d   = busy_q ? in8[sel3_q] : 1'b0;
    valid_d = busy_q;

    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          gnt_d   = onehot8(pick);
          sel3_d  = pick;
          last_d  = pick;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (req[sel3_q] && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (any) begin
          // Back-to-back re-pick; a sole requester picks itself again because
          // the search wraps all the way round to last.
          gnt_d  = onehot8(pick);
          sel3_d = pick;
          last_d = pick;
          cnt_d  = CNT_LOAD;
        end else begin
          // sel3 and last keep their values while idle.
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel3_q  <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);  // requester 0 gets first priority
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel3_q  <= sel3_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel3  = sel3_q;
  assign busy  = busy_q;
  assign out   = out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed scenarios then random traffic against a reference model.
// Latency: model predicts register contents after every rising edge.
// Backpressure: not applicable; inputs change freely each cycle.
module tb_mux8_rr_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] in8;
  logic [7:0] gnt;
  logic [2:0] sel3;
  logic       busy;
  logic       out;
  logic       valid;

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the mux (-1 = nobody), how many cycles it has had.
  int         m_holder = -1;
  int         m_used   = 0;
  int         m_last   = 7;
  int         m_sel    = 0;
  logic       m_out    = 1'b0;
  logic       m_valid  = 1'b0;

  mux8_rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .in8   (in8),
    .gnt   (gnt),
    .sel3  (sel3),
    .busy  (busy),
    .out   (out),
    .valid (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs that are about to be sampled.
  task automatic model_edge();
    bit was_busy;
    bit need;
    was_busy = (m_holder >= 0);
    if (rst) begin
      m_holder = -1; m_used = 0; m_last = 7; m_sel = 0;
      m_out = 1'b0;  m_valid = 1'b0;
    end else begin
      m_out   = was_busy ? in8[m_sel] : 1'b0;
      m_valid = was_busy;
      need = (m_holder < 0) || (m_used >= HOLD) || !req[m_holder];
      if (!need) begin
        m_used++;
      end else if (req != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          if (req[(m_last + k) % 8]) begin
            m_holder = (m_last + k) % 8;
            break;
          end
        end
        m_last = m_holder;
        m_sel  = m_holder;
        m_used = 1;
      end else begin
        m_holder = -1;
      end
    end
  endtask

  task automatic tick();
    logic [7:0] eg;
    model_edge();
    @(posedge clk);
    #1;
    eg = (m_holder < 0) ? 8'h00 : (8'h01 << m_holder);
    chk("gnt",   gnt,          eg);
    chk("sel3",  {5'd0, sel3}, 8'(m_sel));
    chk("busy",  {7'd0, busy}, {7'd0, (m_holder >= 0)});
    chk("out",   {7'd0, out},  {7'd0, m_out});
    chk("valid", {7'd0, valid},{7'd0, m_valid});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 8'hFF;
    in8 = 8'h00;
    @(negedge clk);

    // 1: reset held with all requests up.
    do_reset(2);
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_valid", {7'd0, valid}, 8'h00);

    // 2: single requester 3 re-granted to itself, data toggling.
    req = 8'h08;
    for (int i = 0; i < 14; i++) begin
      in8 = 8'($urandom);
      tick();
      chk("solo_gnt", gnt, 8'h08);
    end

    // 3: everyone requesting: 0..7 then 0, 4 cycles each.
    do_reset(1);
    req = 8'hFF;
    for (int i = 0; i < 36; i++) begin
      in8 = 8'($urandom);
      tick();
      chk("rr_gnt", gnt, 8'h01 << ((i / HOLD) % 8));
    end

    // 4: early release of 5 hands over to 6 on the next edge.
    do_reset(1);
    req = 8'h20;
    tick();
    tick();
    chk("er_gnt5", gnt, 8'h20);
    req = 8'h40;
    tick();
    chk("er_gnt6", gnt, 8'h40);
    req = 8'h60;
    for (int i = 0; i < 3; i++) tick();
    chk("er_hold6", gnt, 8'h40);
    tick();
    chk("er_back5", gnt, 8'h20);

    // 5: wrap from 7 to 0, then idle.
    do_reset(1);
    req = 8'h40;
    tick();
    req = 8'h81;
    tick();
    chk("wrap_7", gnt, 8'h80);
    for (int i = 0; i < HOLD; i++) tick();
    chk("wrap_0", gnt, 8'h01);
    req = 8'h00;
    tick();
    chk("idle_gnt", gnt, 8'h00);
    chk("idle_valid_lag", {7'd0, valid}, 8'h01);
    tick();
    chk("idle_valid", {7'd0, valid}, 8'h00);

    // 6: reset mid-grant of 4; afterwards 4 is picked first again.
    req = 8'h30;
    tick();
    chk("mid_gnt4", gnt, 8'h10);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst", gnt, 8'h00);
    rst = 1'b0;
    tick();
    chk("post_rst", gnt, 8'h10);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      in8 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: req = 8'h00;
          1: req = 8'h01 << $urandom_range(0, 7);
          default: req = 8'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
